// File: rtl/program_driver_if.sv
// Handshake and serial bundle between the program driver and the tiny processor / bench.
// The slave side is the driver itself; the master side is whoever drives its inputs.
interface program_driver_if;
    logic       drive;
    logic       done_in;
    logic       mosi;
    logic       cs;
    logic       miso;
    logic       mosi_out;
    logic [1:0] mode_out;
    logic       done_out;

    modport master (
        output drive, done_in, mosi, cs,
        input  miso, mosi_out, mode_out, done_out
    );

    modport slave (
        input  drive, done_in, mosi, cs,
        output miso, mosi_out, mode_out, done_out
    );
endinterface

// File: rtl/program_driver.sv
// Serially loads fixed instruction and register images into the tiny processor, lets it run,
// flags completion, and independently serves as a bit-serial SPI slave data memory.
module program_driver #(
    parameter int nInstructions = 16,
    parameter int nRegisters    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    program_driver_if.slave  bus
);
    localparam int AW       = $clog2(nRegisters);
    localparam int LOAD_MAX = (nInstructions > nRegisters) ? nInstructions : nRegisters;
    localparam int CNT_W    = $clog2(LOAD_MAX * 8);
    localparam logic [CNT_W-1:0] LAST_I   = CNT_W'(nInstructions * 8 - 1);
    localparam logic [CNT_W-1:0] LAST_R   = CNT_W'(nRegisters * 8 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_I = 3'd1,
        ST_LOAD_R = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] load_cnt_r;
    logic [CNT_W-1:0] load_nxt_s;
    logic             mosi_out_r;
    logic [1:0]       mode_out_r;
    logic             done_out_r;

    logic [4:0]       spi_cnt_r;
    logic [6:0]       cmd_r;
    logic [6:0]       data_r;
    logic             rw_r;
    logic [AW-1:0]    addr_r;
    logic [AW-1:0]    cmd_addr_s;
    logic             miso_r;
    logic [7:0]       mem_r [nRegisters];

    // Load counter value is the image bit index: word = idx/8, bit sent MSB first.
    function automatic logic instr_bit(input logic [CNT_W-1:0] idx);
        logic [7:0] word_v;
        word_v = 8'(idx >> 3);
        return word_v[3'd7 - idx[2:0]];
    endfunction

    function automatic logic reg_bit(input logic [CNT_W-1:0] idx);
        logic [7:0] word_v;
        word_v = 8'hF0 - 8'(idx >> 3);
        return word_v[3'd7 - idx[2:0]];
    endfunction

    assign load_nxt_s = load_cnt_r + CNT_ONE;
    assign cmd_addr_s = {cmd_r[AW-2:0], bus.mosi};

    // Load/run sequencer; outputs are registered alongside the state so each bit lines up with its mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            load_cnt_r <= CNT_ZERO;
            mosi_out_r <= 1'b0;
            mode_out_r <= 2'b00;
            done_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_out_r <= 1'b0;
                    if (bus.drive) begin
                        state_r    <= ST_LOAD_I;
                        load_cnt_r <= CNT_ZERO;
                        mode_out_r <= 2'b01;
                        mosi_out_r <= instr_bit(CNT_ZERO);
                    end else begin
                        mode_out_r <= 2'b00;
                        mosi_out_r <= 1'b0;
                    end
                end
                ST_LOAD_I: begin
                    if (load_cnt_r == LAST_I) begin
                        state_r    <= ST_LOAD_R;
                        load_cnt_r <= CNT_ZERO;
                        mode_out_r <= 2'b10;
                        mosi_out_r <= reg_bit(CNT_ZERO);
                    end else begin
                        load_cnt_r <= load_nxt_s;
                        mosi_out_r <= instr_bit(load_nxt_s);
                    end
                end
                ST_LOAD_R: begin
                    if (load_cnt_r == LAST_R) begin
                        state_r    <= ST_RUN;
                        load_cnt_r <= CNT_ZERO;
                        mode_out_r <= 2'b11;
                        mosi_out_r <= 1'b0;
                    end else begin
                        load_cnt_r <= load_nxt_s;
                        mosi_out_r <= reg_bit(load_nxt_s);
                    end
                end
                ST_RUN: begin
                    if (bus.done_in) begin
                        state_r    <= ST_DONE;
                        mode_out_r <= 2'b00;
                        done_out_r <= 1'b1;
                    end else begin
                        mode_out_r <= 2'b11;
                    end
                end
                ST_DONE: begin
                    if (!bus.drive) begin
                        state_r    <= ST_IDLE;
                        done_out_r <= 1'b0;
                    end else begin
                        done_out_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    load_cnt_r <= CNT_ZERO;
                    mosi_out_r <= 1'b0;
                    mode_out_r <= 2'b00;
                    done_out_r <= 1'b0;
                end
            endcase
        end
    end

    // SPI slave: 8 command bits, then 8 read-out or write-in bits; count saturates at 16 until cs rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spi_cnt_r <= 5'd0;
            cmd_r     <= 7'd0;
            data_r    <= 7'd0;
            rw_r      <= 1'b0;
            addr_r    <= {AW{1'b0}};
            miso_r    <= 1'b0;
            for (int i = 0; i < nRegisters; i++) begin
                mem_r[i] <= 8'hF0 - 8'(i);
            end
        end else if (bus.cs) begin
            spi_cnt_r <= 5'd0;
            miso_r    <= 1'b0;
        end else if (spi_cnt_r < 5'd7) begin
            cmd_r     <= {cmd_r[5:0], bus.mosi};
            spi_cnt_r <= spi_cnt_r + 5'd1;
            miso_r    <= 1'b0;
        end else if (spi_cnt_r == 5'd7) begin
            rw_r      <= cmd_r[6];
            addr_r    <= cmd_addr_s;
            miso_r    <= cmd_r[6] ? 1'b0 : mem_r[cmd_addr_s][7];
            spi_cnt_r <= 5'd8;
        end else if (spi_cnt_r < 5'd15) begin
            // Counts 8..14 present read bits 6..0; the low three count bits give the offset.
            data_r    <= {data_r[5:0], bus.mosi};
            miso_r    <= rw_r ? 1'b0 : mem_r[addr_r][3'd6 - spi_cnt_r[2:0]];
            spi_cnt_r <= spi_cnt_r + 5'd1;
        end else if (spi_cnt_r == 5'd15) begin
            if (rw_r) begin
                mem_r[addr_r] <= {data_r, bus.mosi};
            end else begin
                mem_r[addr_r] <= mem_r[addr_r];
            end
            miso_r    <= 1'b0;
            spi_cnt_r <= 5'd16;
        end else begin
            miso_r    <= 1'b0;
        end
    end

    assign bus.miso     = miso_r;
    assign bus.mosi_out = mosi_out_r;
    assign bus.mode_out = mode_out_r;
    assign bus.done_out = done_out_r;
endmodule

// File: tb/tb_program_driver.sv
// Bench for program_driver: table-driven and random SPI transactions against a memory model,
// plus load/run sequencing checked against streams built from the image definitions.
module tb_program_driver;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   mem_m [16];
    logic [2:0] stream_m [256];

    program_driver_if bus ();

    program_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [15:0] payload;
        int          nbits;
        logic [7:0]  exp_rd;
    } spi_vec_t;

    spi_vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic init_model();
        for (int i = 0; i < 16; i++) mem_m[i] = 240 - i;
    endtask

    // One cs-low transaction: cmd, then nbits payload bits, then cs high; miso checked every cycle.
    task automatic spi_xfer(input string name, input logic [7:0] cmd, input logic [15:0] payload,
                            input int nbits, input logic [7:0] exp_rd);
        logic is_read;
        logic [15:0] pl;
        logic [7:0]  ex;
        is_read = ~cmd[7];
        pl = payload;
        ex = exp_rd;
        bus.cs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mosi = cmd[7 - i];
            tick();
            if (i < 7) chk({name, "_miso_cmd"}, {31'd0, bus.miso}, 32'd0);
            else       chk({name, "_miso_d7"}, {31'd0, bus.miso}, {31'd0, is_read & ex[7]});
        end
        for (int j = 0; j < nbits; j++) begin
            bus.mosi = pl[15 - j];
            tick();
            if (is_read && j < 7) chk({name, "_miso_data"}, {31'd0, bus.miso}, {31'd0, ex[6 - j]});
            else                  chk({name, "_miso_tail"}, {31'd0, bus.miso}, 32'd0);
        end
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        tick();
        chk({name, "_miso_idle"}, {31'd0, bus.miso}, 32'd0);
        if (!is_read && nbits >= 8) mem_m[cmd[3:0]] = int'(pl[15:8]);
    endtask

    // Check nc cycles of the load stream; optionally wiggle drive mid-load to show it is ignored.
    task automatic check_load(input int nc, input bit wiggle);
        for (int k = 0; k < nc; k++) begin
            if (wiggle && k == 50)  bus.drive = 1'b0;
            if (wiggle && k == 100) bus.drive = 1'b1;
            tick();
            chk("load_stream", {29'd0, bus.mode_out, bus.mosi_out}, {29'd0, stream_m[k]});
        end
    endtask

    task automatic run_and_finish();
        tick();
        chk("run_mode", {30'd0, bus.mode_out}, 32'd3);
        chk("run_mosi", {31'd0, bus.mosi_out}, 32'd0);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("run_hold", {29'd0, bus.mode_out, bus.done_out}, {29'd0, 2'b11, 1'b0});
        end
        bus.done_in = 1'b1;
        tick();
        chk("done_set", {29'd0, bus.mode_out, bus.done_out}, {29'd0, 2'b00, 1'b1});
        bus.done_in = 1'b0;
        tick();
        chk("done_hold", {29'd0, bus.mode_out, bus.done_out}, {29'd0, 2'b00, 1'b1});
        bus.drive = 1'b0;
        tick();
        chk("done_clear", {29'd0, bus.mode_out, bus.done_out}, 32'd0);
        tick();
        chk("idle_after", {28'd0, bus.mode_out, bus.done_out, bus.mosi_out}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Expected load stream from the image definitions: 16 instr words then 16 reg words, MSB first.
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 8; b++) begin
                stream_m[w * 8 + b]       = {2'b01, 1'(((w) >> (7 - b)) & 1)};
                stream_m[128 + w * 8 + b] = {2'b10, 1'(((240 - w) >> (7 - b)) & 1)};
            end
        end
        vecs[0] = '{"rd3",      8'h03, 16'h0000, 8,  8'hED};
        vecs[1] = '{"wr5",      8'h85, 16'h5A00, 8,  8'h00};
        vecs[2] = '{"rd5",      8'h05, 16'h0000, 8,  8'h5A};
        vecs[3] = '{"wr6abort", 8'h86, 16'hF000, 4,  8'h00};
        vecs[4] = '{"rd6",      8'h06, 16'h0000, 8,  8'hEA};
        vecs[5] = '{"wr7extra", 8'h87, 16'h3CFF, 16, 8'h00};
        vecs[6] = '{"rd7extra", 8'h07, 16'hFFFF, 16, 8'h3C};
        vecs[7] = '{"rdabort",  8'h00, 16'h0000, 3,  8'hF0};
        vecs[8] = '{"wr0",      8'h80, 16'h1100, 8,  8'h00};
        vecs[9] = '{"rd0",      8'h00, 16'h0000, 8,  8'h11};

        bus.drive = 1'b0; bus.done_in = 1'b0; bus.mosi = 1'b0; bus.cs = 1'b1;
        rst_n = 1'b0;
        init_model();
        for (int i = 0; i < 10; i++) tick();
        chk("rst_mode", {30'd0, bus.mode_out}, 32'd0);
        chk("rst_done", {31'd0, bus.done_out}, 32'd0);
        chk("rst_miso", {31'd0, bus.miso}, 32'd0);
        chk("rst_mosi_out", {31'd0, bus.mosi_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_outputs", {28'd0, bus.mode_out, bus.done_out, bus.mosi_out}, 32'd0);

        for (int v = 0; v < 10; v++)
            spi_xfer(vecs[v].name, vecs[v].cmd, vecs[v].payload, vecs[v].nbits, vecs[v].exp_rd);

        bus.drive = 1'b1;
        check_load(256, 1'b1);
        run_and_finish();

        for (int t = 0; t < 40; t++) begin
            logic [3:0]  a;
            logic        rw;
            logic [15:0] pl;
            int          sel;
            int          nb;
            a   = 4'($urandom_range(0, 15));
            rw  = 1'($urandom_range(0, 1));
            pl  = 16'($urandom);
            sel = $urandom_range(0, 3);
            nb  = (sel == 0) ? $urandom_range(0, 7) : (sel == 1) ? 8 + $urandom_range(0, 8) : 8;
            spi_xfer("rand", {rw, 3'b000, a}, pl, nb, 8'(mem_m[a]));
        end
        for (int a = 0; a < 16; a++)
            spi_xfer("sweep", {4'h0, 4'(a)}, 16'h0000, 8, 8'(mem_m[a]));

        // Reset during the register load, then confirm SPI memory and sequencing restart cleanly.
        bus.drive = 1'b1;
        check_load(140, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midrst_mode", {30'd0, bus.mode_out}, 32'd0);
        chk("midrst_mosi_out", {31'd0, bus.mosi_out}, 32'd0);
        chk("midrst_done", {31'd0, bus.done_out}, 32'd0);
        rst_n = 1'b1;
        bus.drive = 1'b0;
        init_model();
        tick();
        spi_xfer("rd5_after_rst", 8'h05, 16'h0000, 8, 8'hEB);
        spi_xfer("rd0_after_rst", 8'h00, 16'h0000, 8, 8'hF0);
        bus.drive = 1'b1;
        check_load(256, 1'b0);
        run_and_finish();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
